// File: rtl/ldl_rr_pri_pkg.sv
// Shared constants and helpers for the request-FIFO front end of the priority arbiter.
// Holds the wait-counter saturation value and the one-hot-to-binary encoder.
package ldl_rr_pri_pkg;

  localparam int AGE_W = 4;
  localparam logic [AGE_W-1:0] AGE_MAX = 4'd15;

  // Widest one-hot vector the encoder accepts; callers zero-extend into it.
  localparam int ONEHOT_MAX   = 256;
  localparam int ONEHOT_IDX_W = 8;

  function automatic logic [ONEHOT_IDX_W-1:0] onehot_to_bin(input logic [ONEHOT_MAX-1:0] vec);
    logic [ONEHOT_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ONEHOT_MAX; i++) begin
      if (vec[i]) idx = idx | ONEHOT_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ldl_rr_req_fifo_v1.sv
// Per-port synchronous FIFO; pointers carry one extra wrap bit so full and
// empty are told apart without a separate counter.
module ldl_rr_req_fifo_v1 #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_data = mem[rd_ptr_q[AW-1:0]];

  // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop && !empty) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; empty pointers make its contents unobservable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ldl_rr_pri_req_v1.sv
// Per-port request FIFOs feeding an external priority arbiter, with a registered
// grant output stage. Optional head-of-line aging is enabled by LDL_RR_PRI_AGING_EN.
module ldl_rr_pri_req_v1
  import ldl_rr_pri_pkg::*;
#(
  parameter int BIN_WIDTH  = 3,
  parameter int COS_WIDTH  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int REQ_WIDTH  = 1 << BIN_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [REQ_WIDTH-1:0]            in_valid,
  output logic [REQ_WIDTH-1:0]            in_ready,
  input  logic [REQ_WIDTH*DATA_WIDTH-1:0] in_data,
  input  logic [REQ_WIDTH*COS_WIDTH-1:0]  in_cos,
  output logic [REQ_WIDTH-1:0]            req,
  output logic [REQ_WIDTH*COS_WIDTH-1:0]  cos,
  input  logic [REQ_WIDTH-1:0]            hot,
  input  logic                            valid,
  output logic                            ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [BIN_WIDTH-1:0]            out_port,
  output logic [COS_WIDTH-1:0]            out_cos,
  output logic                            err
);

  localparam int EW = DATA_WIDTH + COS_WIDTH;

  logic [REQ_WIDTH-1:0]  full, empty, pop;
  logic [DATA_WIDTH-1:0] head_data [REQ_WIDTH];
  logic [COS_WIDTH-1:0]  head_cos  [REQ_WIDTH];
  logic [BIN_WIDTH-1:0]  hot_idx;
  logic                  hot_onehot, grant, bad_grant;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [BIN_WIDTH-1:0]  out_port_q,  out_port_d;
  logic [COS_WIDTH-1:0]  out_cos_q,   out_cos_d;
  logic                  err_q,       err_d;

  for (genvar g = 0; g < REQ_WIDTH; g++) begin : g_port
    logic [EW-1:0] head_entry;

    ldl_rr_req_fifo_v1 #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid[g] && in_ready[g]),
      .push_data ({in_data[g*DATA_WIDTH +: DATA_WIDTH], in_cos[g*COS_WIDTH +: COS_WIDTH]}),
      .pop       (pop[g]),
      .head_data (head_entry),
      .full      (full[g]),
      .empty     (empty[g])
    );

    assign head_data[g] = head_entry[EW-1:COS_WIDTH];
    assign head_cos[g]  = head_entry[COS_WIDTH-1:0];
  end

  assign in_ready = ~full;
  assign req      = ~empty;
  assign ready    = !out_valid_q || out_ready;

  // A grant must name exactly one port that actually holds an entry.
  assign hot_onehot = (hot != '0) && ((hot & (hot - REQ_WIDTH'(1))) == '0);
  assign hot_idx    = BIN_WIDTH'(onehot_to_bin(ONEHOT_MAX'(hot)));
  assign grant      = valid && ready && hot_onehot && req[hot_idx];
  assign bad_grant  = valid && ready && !grant;
  assign pop        = grant ? hot : '0;

`ifdef LDL_RR_PRI_AGING_EN
  logic [AGE_W-1:0] age_q [REQ_WIDTH];
  logic [AGE_W-1:0] age_d [REQ_WIDTH];

  always_comb begin
    for (int i = 0; i < REQ_WIDTH; i++) begin
      age_d[i] = age_q[i];
      if (!req[i] || pop[i])       age_d[i] = '0;
      else if (age_q[i] != AGE_MAX) age_d[i] = age_q[i] + AGE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REQ_WIDTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < REQ_WIDTH; i++) age_q[i] <= age_d[i];
    end
  end
`endif

  // Empty ports report class 0 so uninitialised storage never reaches the arbiter.
  always_comb begin
    cos = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      if (!empty[i]) cos[i*COS_WIDTH +: COS_WIDTH] = head_cos[i];
`ifdef LDL_RR_PRI_AGING_EN
      if (!empty[i] && age_q[i] == AGE_MAX) cos[i*COS_WIDTH +: COS_WIDTH] = '1;
`endif
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_port_d  = out_port_q;
    out_cos_d   = out_cos_q;
    err_d       = err_q || bad_grant;
    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = head_data[hot_idx];
      out_port_d  = hot_idx;
      out_cos_d   = head_cos[hot_idx];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_port_q  <= '0;
      out_cos_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_port_q  <= out_port_d;
      out_cos_q   <= out_cos_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_port  = out_port_q;
  assign out_cos   = out_cos_q;
  assign err       = err_q;

endmodule

// File: doc/ldl_rr_pri_req_v1.md
LDL_RR_PRI_REQ_V1 -- requirements
Module: LDL_rr_pri_req_v1

Interface
REQ-001 SHALL have parameter BIN_WIDTH, default 3, meaning log2 of the port count.
REQ-002 SHALL have parameter COS_WIDTH, default 2, meaning class-of-service width, where 0 is the lowest class.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning the payload width.
REQ-004 SHALL have parameter DEPTH, default 4, meaning per-port FIFO entries (power of 2, at least 2).
REQ-005 SHALL have parameter REQ_WIDTH, default 1<<BIN_WIDTH, meaning the port count.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk input 1, the single clock; rst input 1, the asynchronous active-low reset.
REQ-007 SHALL have the following ports, one per line as name, direction, width, meaning:
- in_valid  input  REQ_WIDTH  per-port write strobe
- in_ready  output  REQ_WIDTH  per-port space available
- in_data  input  REQ_WIDTH x DATA_WIDTH  per-port payload
- in_cos  input  REQ_WIDTH x COS_WIDTH  per-port class
- req  output  REQ_WIDTH  request vector to the priority arbiter
- cos  output  REQ_WIDTH x COS_WIDTH  class vector to the arbiter
- hot  input  REQ_WIDTH  one-hot grant from the arbiter
- valid  input  1  arbiter grant valid
- ready  output  1  grant accepted (drives the arbiter ready)
- out_valid  output  1  registered output valid
- out_ready  input  1  downstream accept
- out_data  output  DATA_WIDTH  granted payload
- out_port  output  BIN_WIDTH  granted port index
- out_cos  output  COS_WIDTH  granted entry's original in_cos
- err  output  1  sticky protocol-error flag

Function
REQ-008 SHALL write {in_data, in_cos} into port i's FIFO at the clk edge where in_valid[i] && in_ready[i].
REQ-009 SHALL drive in_ready[i] = !full[i] from registered state only, so a push to a full FIFO SHALL NOT be accepted even if a pop occurs in the same cycle.
REQ-010 SHALL drive req[i] = !empty[i] and cos[i] = class of port i's head entry, both registered-state-derived with no combinational path from in_* inputs.
REQ-011 SHALL drive ready = !out_valid || out_ready.
REQ-012 SHALL define grant as valid && ready && hot one-hot && req[hot index].
REQ-013 On grant, SHALL pop the head of the granted FIFO and load out_data, out_port (binary index of hot) and out_cos, with out_valid=1, at the same edge.
REQ-014 SHALL hold out_* stable while out_valid && !out_ready, and clear out_valid on out_ready without a new grant.
REQ-015 SHALL give minimum latency of 2 edges from input accept to out_valid, and sustain 1 grant per cycle when out_ready=1.
REQ-016 SHALL accept a simultaneous push and pop on the same non-full port in the same cycle, leaving the count unchanged.
REQ-017 SHALL wrap FIFO pointers modulo DEPTH, with full/empty distinguished by an extra pointer bit.
REQ-018 If valid && ready and hot is zero, not one-hot, or targets an empty port, SHALL pop nothing, leave out_* unchanged, and set err=1 until reset.
REQ-019 If valid=0, SHALL ignore hot.

Reset
REQ-020 While rst=0, SHALL asynchronously empty all FIFOs.
REQ-021 While rst=0, SHALL force in_ready=all 1, req=0, cos=0, out_valid=0, out_data=0, out_port=0, out_cos=0 and err=0.
REQ-022 SHALL discard any in-flight output entry when reset is asserted mid-operation.
REQ-023 SHALL leave FIFO storage arrays un-reset, with content irrelevant while empty.

Configuration
REQ-024 With LDL_RR_PRI_AGING_EN defined, port i SHALL have a 4-bit saturating wait counter.
REQ-025 The wait counter SHALL increment each cycle req[i]=1 without a grant to i, and clear on grant to i or when empty.
REQ-026 While the wait counter equals 15, cos[i] SHALL be driven all-ones while out_cos keeps the stored class.
REQ-027 Without LDL_RR_PRI_AGING_EN, SHALL instantiate no counters and drive cos[i] = head class exactly.

Structure
REQ-028 Package LDL_rr_pri_pkg SHALL hold the one-hot-to-binary function and the AGE_MAX=15 constant.
REQ-029 SHALL use one sub-module, LDL_rr_req_fifo_v1, a per-port synchronous FIFO of DEPTH x (DATA_WIDTH+COS_WIDTH), instantiated REQ_WIDTH times via generate.

Verification
REQ-030 Push port 2 data 0xA5, cos 1; arbiter hot=8'h04, valid=1 -> out_valid two edges after accept, out_data=0xA5, out_port=2, out_cos=1, req[2]=0 afterwards.
REQ-031 Push 4 entries to port 0 with no grant -> in_ready[0]=0; 5th push is ignored; after one grant in_ready[0]=1 and the data order is preserved.
REQ-032 With out_ready=0 and out_valid=1, grant pulse -> ready=0, no pop, out_* stable; release out_ready -> next grant accepted.
REQ-033 valid=1, hot=8'h03 or hot to an empty port -> err=1 and no FIFO count change; rst low mid-stream -> all outputs at reset values immediately.
REQ-034 LDL_RR_PRI_AGING_EN: port 1 cos 0 blocked 15 cycles by port 3 cos 3 -> cos[1]=3; after grant to 1, cos[1] returns to head class; without the macro cos[1] stays 0.
